// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch (imem) and data (dmem) requesters.
// Fixed dmem-over-imem priority by default; define MEM_ARB_ROUND_ROBIN_EN for round-robin ties.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int NUM_SIDES = 2;
  localparam int SIDE_I    = 0;
  localparam int SIDE_D    = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state_reg;

  logic [31:0] mem_addr_reg;
  logic [3:0]  mem_rmask_reg;
  logic [3:0]  mem_wmask_reg;
  logic [31:0] mem_wdata_reg;

  // Uniform per-side view of the request inputs; fetch never writes.
  logic [31:0] req_addr  [NUM_SIDES];
  logic [3:0]  req_rmask [NUM_SIDES];
  logic [3:0]  req_wmask [NUM_SIDES];
  logic [31:0] req_wdata [NUM_SIDES];

  assign req_addr[SIDE_I]  = imem_addr;
  assign req_rmask[SIDE_I] = imem_rmask;
  assign req_wmask[SIDE_I] = 4'h0;
  assign req_wdata[SIDE_I] = 32'h0;
  assign req_addr[SIDE_D]  = dmem_addr;
  assign req_rmask[SIDE_D] = dmem_rmask;
  assign req_wmask[SIDE_D] = dmem_wmask;
  assign req_wdata[SIDE_D] = dmem_wdata;

  logic [NUM_SIDES-1:0] in_flight;
  logic [NUM_SIDES-1:0] resp_now;
  logic [NUM_SIDES-1:0] new_req;
  logic [NUM_SIDES-1:0] accept;
  logic [NUM_SIDES-1:0] eligible;
  logic [NUM_SIDES-1:0] pend_valid;
  logic [NUM_SIDES-1:0] grant_onehot;

  logic [31:0] cand_addr  [NUM_SIDES];
  logic [3:0]  cand_rmask [NUM_SIDES];
  logic [3:0]  cand_wmask [NUM_SIDES];
  logic [31:0] cand_wdata [NUM_SIDES];

  logic        issue;
  logic        grant_d;
  logic [31:0] win_addr;
  logic [3:0]  win_rmask;
  logic [3:0]  win_wmask;
  logic [31:0] win_wdata;

  assign in_flight[SIDE_I] = (state_reg == BUSY_I);
  assign in_flight[SIDE_D] = (state_reg == BUSY_D);
  assign resp_now          = in_flight & {NUM_SIDES{mem_resp}};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SIDES; gi++) begin : g_side
      logic        pend_valid_reg;
      logic [31:0] pend_addr_reg;
      logic [3:0]  pend_rmask_reg;
      logic [3:0]  pend_wmask_reg;
      logic [31:0] pend_wdata_reg;

      assign new_req[gi]    = (req_rmask[gi] != 4'h0) || (req_wmask[gi] != 4'h0);
      // A side may only have one request outstanding, except that a new one
      // may ride along with the response that retires the previous one.
      assign accept[gi]     = new_req[gi] && !pend_valid_reg && (!in_flight[gi] || resp_now[gi]);
      assign eligible[gi]   = pend_valid_reg || accept[gi];
      assign pend_valid[gi] = pend_valid_reg;

      assign cand_addr[gi]  = pend_valid_reg ? pend_addr_reg  : req_addr[gi];
      assign cand_rmask[gi] = pend_valid_reg ? pend_rmask_reg : req_rmask[gi];
      assign cand_wmask[gi] = pend_valid_reg ? pend_wmask_reg : req_wmask[gi];
      assign cand_wdata[gi] = pend_valid_reg ? pend_wdata_reg : req_wdata[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          pend_valid_reg <= 1'b0;
          pend_addr_reg  <= 32'h0;
          pend_rmask_reg <= 4'h0;
          pend_wmask_reg <= 4'h0;
          pend_wdata_reg <= 32'h0;
        end else if (grant_onehot[gi]) begin
          pend_valid_reg <= 1'b0;
        end else if (accept[gi]) begin
          pend_valid_reg <= 1'b1;
          pend_addr_reg  <= req_addr[gi];
          pend_rmask_reg <= req_rmask[gi];
          pend_wmask_reg <= req_wmask[gi];
          pend_wdata_reg <= req_wdata[gi];
        end
      end
    end
  endgenerate

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_reg;  // 1 = dmem was granted most recently

  always_comb begin
    grant_d = eligible[SIDE_D];
    if (eligible[SIDE_D] && eligible[SIDE_I]) begin
      grant_d = !last_grant_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b0;
    end else if (issue) begin
      last_grant_reg <= grant_d;
    end
  end
`else
  assign grant_d = eligible[SIDE_D];
`endif

  assign issue        = (state_reg == IDLE) && (eligible != '0);
  assign grant_onehot = issue ? (grant_d ? 2'b10 : 2'b01) : 2'b00;

  assign win_addr  = grant_d ? cand_addr[SIDE_D]  : cand_addr[SIDE_I];
  assign win_rmask = grant_d ? cand_rmask[SIDE_D] : cand_rmask[SIDE_I];
  assign win_wmask = grant_d ? cand_wmask[SIDE_D] : cand_wmask[SIDE_I];
  assign win_wdata = grant_d ? cand_wdata[SIDE_D] : cand_wdata[SIDE_I];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mem_addr_reg  <= 32'h0;
      mem_rmask_reg <= 4'h0;
      mem_wmask_reg <= 4'h0;
      mem_wdata_reg <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (issue) begin
            state_reg     <= grant_d ? BUSY_D : BUSY_I;
            mem_addr_reg  <= win_addr;
            mem_rmask_reg <= win_rmask;
            mem_wmask_reg <= win_wmask;
            mem_wdata_reg <= win_wdata;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_resp) begin
            state_reg     <= IDLE;
            mem_rmask_reg <= 4'h0;
            mem_wmask_reg <= 4'h0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          mem_rmask_reg <= 4'h0;
          mem_wmask_reg <= 4'h0;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_rmask = mem_rmask_reg;
  assign mem_wmask = mem_wmask_reg;
  assign mem_wdata = mem_wdata_reg;

  // Responses pass straight through in the completion cycle; stores return zero data.
  assign imem_resp  = resp_now[SIDE_I];
  assign dmem_resp  = resp_now[SIDE_D];
  assign imem_rdata = imem_resp ? mem_rdata : 32'h0;
  assign dmem_rdata = (dmem_resp && (mem_wmask_reg == 4'h0)) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks for mem_port_arbiter against a queue-based scoreboard
// and a latency-programmable memory responder.
module tb_mem_port_arbiter;

  localparam int NUM_RND = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_addr   (mem_addr),
    .mem_rmask  (mem_rmask),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } req_t;

  req_t q_i[$];
  req_t q_d[$];
  bit   iss [2];

  int n_cmp = 0;
  int n_err = 0;

  // memory responder state
  bit mm_auto, mm_rand, mm_busy;
  int mm_cnt, mm_lat, mm_lat_cfg;

  // scoreboard / generator state
  bit sb_en, gen_en, dn_active, dn_owner;
  int n_gen, n_resp, cnt_iresp, cnt_dresp;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_rmask, h_wmask;

  // per-cycle samples
  logic [31:0] s_mem_addr, s_mem_wdata, s_irdata, s_drdata;
  logic [3:0]  s_mem_rmask, s_mem_wmask;
  logic        s_iresp, s_dresp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic score();
    req_t f;
    bit   ok;
    logic mask_on;
    mask_on = (s_mem_rmask != 4'h0) || (s_mem_wmask != 4'h0);
    if (dn_active) begin
      chk("rnd_busy_mask_held", mask_on, 1);
      chk("rnd_hold_addr", s_mem_addr, h_addr);
      chk("rnd_hold_rmask", s_mem_rmask, h_rmask);
      chk("rnd_hold_wmask", s_mem_wmask, h_wmask);
      chk("rnd_hold_wdata", s_mem_wdata, h_wdata);
    end else if (mask_on) begin
      dn_owner = s_mem_addr[28];
      ok = dn_owner ? (q_d.size() > 0 && !iss[1]) : (q_i.size() > 0 && !iss[0]);
      chk("rnd_issue_pending", ok, 1);
      if (ok) begin
        f = dn_owner ? q_d[0] : q_i[0];
        chk("rnd_issue_addr", s_mem_addr, f.addr);
        chk("rnd_issue_rmask", s_mem_rmask, f.rmask);
        chk("rnd_issue_wmask", s_mem_wmask, f.wmask);
        if (f.wmask != 4'h0) chk("rnd_issue_wdata", s_mem_wdata, f.wdata);
        iss[dn_owner] = 1'b1;
      end
      dn_active = 1'b1;
      h_addr = s_mem_addr; h_rmask = s_mem_rmask; h_wmask = s_mem_wmask; h_wdata = s_mem_wdata;
    end
    chk("rnd_resp_follows_mem", s_iresp | s_dresp, mem_resp);
    chk("rnd_single_resp", s_iresp & s_dresp, 0);
    if (s_iresp) begin
      ok = dn_active && !dn_owner && q_i.size() > 0 && iss[0];
      chk("rnd_iresp_expected", ok, 1);
      if (ok) begin
        f = q_i.pop_front();
        iss[0] = 1'b0;
        chk("rnd_irdata", s_irdata, mem_word(f.addr));
        n_resp++;
        $display("txn %0d imem load  addr=%08h rdata=%08h", n_resp, f.addr, s_irdata);
      end
    end else begin
      chk("rnd_irdata_idle", s_irdata, 0);
    end
    if (s_dresp) begin
      ok = dn_active && dn_owner && q_d.size() > 0 && iss[1];
      chk("rnd_dresp_expected", ok, 1);
      if (ok) begin
        f = q_d.pop_front();
        iss[1] = 1'b0;
        chk("rnd_drdata", s_drdata, (f.wmask != 4'h0) ? 32'h0 : mem_word(f.addr));
        n_resp++;
        $display("txn %0d dmem %s addr=%08h rdata=%08h", n_resp,
                 (f.wmask != 4'h0) ? "store" : "load ", f.addr, s_drdata);
      end
    end else begin
      chk("rnd_drdata_idle", s_drdata, 0);
    end
    if (mem_resp) dn_active = 1'b0;
  endtask

  // One clock cycle: entered at posedge+1 with this cycle's requests already driven.
  task automatic cycle();
    req_t r;
    bit   resp_i, resp_d;
    if (mm_auto) begin
      if (rst) begin
        mm_busy  = 1'b0;
        mem_resp = 1'b0;
      end else if (mem_rmask != 4'h0 || mem_wmask != 4'h0) begin
        if (!mm_busy) begin
          mm_busy = 1'b1;
          mm_cnt  = 0;
          mm_lat  = mm_rand ? int'($urandom_range(5, 1)) : mm_lat_cfg;
        end else begin
          mm_cnt++;
        end
        mem_resp = (mm_cnt == mm_lat);
      end else begin
        mm_busy  = 1'b0;
        mem_resp = 1'b0;
      end
    end
    mem_rdata = mem_resp ? mem_word(mem_addr) : $urandom();

    if (gen_en) begin
      resp_i = mem_resp && dn_active && !dn_owner;
      resp_d = mem_resp && dn_active && dn_owner;
      if (n_gen < NUM_RND && (q_i.size() == 0 || (q_i.size() == 1 && iss[0] && resp_i))
          && $urandom_range(2, 0) == 0) begin
        r.addr = $urandom();
        r.addr[28] = 1'b0;
        r.addr[1:0] = 2'b00;
        r.rmask = 4'hF;
        r.wmask = 4'h0;
        r.wdata = 32'h0;
        imem_addr = r.addr;
        imem_rmask = r.rmask;
        q_i.push_back(r);
        n_gen++;
      end
      if (n_gen < NUM_RND && (q_d.size() == 0 || (q_d.size() == 1 && iss[1] && resp_d))
          && $urandom_range(2, 0) == 0) begin
        r.addr = $urandom();
        r.addr[28] = 1'b1;
        r.addr[1:0] = 2'b00;
        if ($urandom_range(1, 0) == 0) begin
          r.rmask = 4'(int'($urandom_range(15, 1)));
          r.wmask = 4'h0;
          r.wdata = 32'h0;
        end else begin
          r.rmask = 4'h0;
          r.wmask = 4'(int'($urandom_range(15, 1)));
          r.wdata = $urandom();
        end
        dmem_addr = r.addr;
        dmem_rmask = r.rmask;
        dmem_wmask = r.wmask;
        dmem_wdata = r.wdata;
        q_d.push_back(r);
        n_gen++;
      end
    end

    #2;
    s_mem_addr  = mem_addr;
    s_mem_rmask = mem_rmask;
    s_mem_wmask = mem_wmask;
    s_mem_wdata = mem_wdata;
    s_iresp     = imem_resp;
    s_dresp     = dmem_resp;
    s_irdata    = imem_rdata;
    s_drdata    = dmem_rdata;
    if (s_iresp) cnt_iresp++;
    if (s_dresp) cnt_dresp++;
    if (sb_en) score();
    if (mm_auto && mem_resp) mm_busy = 1'b0;

    @(posedge clk);
    #1;
    imem_rmask = 4'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
  endtask

  task automatic tie_check(input bit d_first, input string tag);
    logic [31:0] a_i, a_d, a1, a2;
    a_i = 32'h1eceb200;
    a_d = 32'h1eceb300;
    a1 = d_first ? a_d : a_i;
    a2 = d_first ? a_i : a_d;
    mm_lat_cfg = 1;
    imem_addr = a_i; imem_rmask = 4'hF;
    dmem_addr = a_d; dmem_rmask = 4'hC;
    cycle();
    chk({tag, "_no_early_issue"}, s_mem_rmask, 0);
    cycle();
    chk({tag, "_first_addr"}, s_mem_addr, a1);
    chk({tag, "_first_rmask"}, s_mem_rmask, d_first ? 4'hC : 4'hF);
    cycle();
    chk({tag, "_first_dresp"}, s_dresp, d_first);
    chk({tag, "_first_iresp"}, s_iresp, !d_first);
    chk({tag, "_first_rdata"}, d_first ? s_drdata : s_irdata, mem_word(a1));
    cycle();
    chk({tag, "_idle_gap"}, s_mem_rmask, 0);
    cycle();
    chk({tag, "_second_addr"}, s_mem_addr, a2);
    chk({tag, "_second_rmask"}, s_mem_rmask, d_first ? 4'hF : 4'hC);
    cycle();
    chk({tag, "_second_dresp"}, s_dresp, !d_first);
    chk({tag, "_second_iresp"}, s_iresp, d_first);
    chk({tag, "_second_rdata"}, d_first ? s_irdata : s_drdata, mem_word(a2));
    cycle();
  endtask

  initial begin
    int base;
    rst = 1'b1;
    imem_addr = 32'h0; imem_rmask = 4'h0;
    dmem_addr = 32'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
    mem_rdata = 32'h0; mem_resp = 1'b0;
    mm_auto = 1'b1; mm_rand = 1'b0; mm_busy = 1'b0; mm_lat_cfg = 2; mm_cnt = 0; mm_lat = 0;
    sb_en = 1'b0; gen_en = 1'b0; dn_active = 1'b0; dn_owner = 1'b0;
    n_gen = 0; n_resp = 0; cnt_iresp = 0; cnt_dresp = 0;
    iss[0] = 1'b0; iss[1] = 1'b0;

    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_mem_addr", s_mem_addr, 0);
    chk("rst_mem_rmask", s_mem_rmask, 0);
    chk("rst_mem_wmask", s_mem_wmask, 0);
    chk("rst_mem_wdata", s_mem_wdata, 0);
    chk("rst_imem_resp", s_iresp, 0);
    chk("rst_dmem_resp", s_dresp, 0);
    chk("rst_imem_rdata", s_irdata, 0);
    chk("rst_dmem_rdata", s_drdata, 0);

    // single fetch, memory latency 2
    mm_lat_cfg = 2;
    imem_addr = 32'h1eceb000; imem_rmask = 4'hF;
    cycle();
    chk("t1_issue_delay", s_mem_rmask, 0);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk("t1_mem_rmask", s_mem_rmask, 4'hF);
      chk("t1_mem_addr", s_mem_addr, 32'h1eceb000);
      chk("t1_imem_resp", s_iresp, (k == 3));
      chk("t1_dmem_resp", s_dresp, 0);
    end
    chk("t1_imem_rdata", s_irdata, mem_word(32'h1eceb000));
    cycle();
    chk("t1_mask_drop", s_mem_rmask, 0);
    chk("t1_resp_drop", s_iresp, 0);
    chk("t1_rdata_drop", s_irdata, 0);

    // store
    dmem_addr = 32'h1eceb100; dmem_wmask = 4'h3; dmem_wdata = 32'hDEADBEEF;
    cycle();
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk("t2_mem_wmask", s_mem_wmask, 4'h3);
      chk("t2_mem_rmask", s_mem_rmask, 0);
      chk("t2_mem_wdata", s_mem_wdata, 32'hDEADBEEF);
      chk("t2_mem_addr", s_mem_addr, 32'h1eceb100);
      chk("t2_dmem_resp", s_dresp, (k == 3));
      chk("t2_dmem_rdata", s_drdata, 0);
      chk("t2_imem_resp", s_iresp, 0);
    end
    cycle();
    chk("t2_wmask_drop", s_mem_wmask, 0);

    // first tie: dmem was granted last, so round-robin favours imem
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_check(1'b0, "tie1");
`else
    tie_check(1'b1, "tie1");
`endif

    // request alongside own response is captured; duplicate while in flight is dropped
    mm_lat_cfg = 2;
    base = cnt_iresp;
    imem_addr = 32'h1eceb400; imem_rmask = 4'hF;
    cycle();
    cycle();
    chk("t4_first_addr", s_mem_addr, 32'h1eceb400);
    imem_addr = 32'h1eceb440; imem_rmask = 4'hF;
    cycle();
    chk("t4_dup_hold_addr", s_mem_addr, 32'h1eceb400);
    imem_addr = 32'h1eceb480; imem_rmask = 4'hF;
    cycle();
    chk("t4_first_resp", s_iresp, 1);
    chk("t4_first_rdata", s_irdata, mem_word(32'h1eceb400));
    cycle();
    chk("t4_idle_gap", s_mem_rmask, 0);
    cycle();
    chk("t4_second_addr", s_mem_addr, 32'h1eceb480);
    chk("t4_second_rmask", s_mem_rmask, 4'hF);
    cycle();
    cycle();
    chk("t4_second_resp", s_iresp, 1);
    chk("t4_second_rdata", s_irdata, mem_word(32'h1eceb480));
    repeat (6) cycle();
    chk("t4_resp_count", cnt_iresp - base, 2);
    chk("t4_final_idle", s_mem_rmask, 0);

    // second tie: imem was granted last, dmem wins under either policy
    tie_check(1'b1, "tie2");

    // reset while BUSY_D, stale response after release
    mm_auto = 1'b0; mem_resp = 1'b0;
    base = cnt_dresp;
    dmem_addr = 32'h1eceb500; dmem_rmask = 4'hF;
    cycle();
    cycle();
    chk("t5_busy_d", s_mem_rmask, 4'hF);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("t5_mask_cleared", s_mem_rmask, 0);
    chk("t5_addr_cleared", s_mem_addr, 0);
    cycle();
    mem_resp = 1'b1;
    cycle();
    chk("t5_no_dresp", s_dresp, 0);
    chk("t5_no_iresp", s_iresp, 0);
    chk("t5_no_drdata", s_drdata, 0);
    chk("t5_masks_idle", s_mem_rmask | s_mem_wmask, 0);
    mem_resp = 1'b0;
    mm_auto = 1'b1; mm_busy = 1'b0; mm_lat_cfg = 1;
    dmem_addr = 32'h1eceb600; dmem_rmask = 4'h3;
    cycle();
    cycle();
    chk("t5_reissue_addr", s_mem_addr, 32'h1eceb600);
    chk("t5_reissue_rmask", s_mem_rmask, 4'h3);
    cycle();
    chk("t5_reissue_resp", s_dresp, 1);
    chk("t5_reissue_rdata", s_drdata, mem_word(32'h1eceb600));
    chk("t5_resp_count", cnt_dresp - base, 1);
    cycle();

    // random interleaved traffic against a 1-5 cycle memory
    mm_rand = 1'b1;
    sb_en = 1'b1;
    gen_en = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if (n_gen >= NUM_RND && q_i.size() == 0 && q_d.size() == 0) break;
      cycle();
    end
    gen_en = 1'b0;
    repeat (5) cycle();
    chk("rnd_gen_count", n_gen, NUM_RND);
    chk("rnd_resp_count", n_resp, n_gen);
    chk("rnd_q_i_left", q_i.size(), 0);
    chk("rnd_q_d_left", q_d.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
